// File: rtl/ifq.sv
// Instruction fetch queue: FIFO of fetched {pc, instr, bp, bt} entries between fetch and decode.
// First-word-fall-through head, no bypass, flush and reset clear pointers and occupancy.
package ifq_pkg;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        bp;
        logic [63:0] bt;
    } ifq_entry_t;
endpackage

module ifq
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_flush,
    input  logic [63:0]              ifp_ifq_pc,
    input  logic [31:0]              ifp_ifq_instr,
    input  logic                     ifp_ifq_bp,
    input  logic [63:0]              ifp_ifq_bt,
    input  logic                     ifp_ifq_valid,
    output logic                     ifp_ifq_ready,
    output logic [63:0]              if_dec_pc,
    output logic [31:0]              if_dec_instr,
    output logic                     if_dec_bp,
    output logic [63:0]              if_dec_bt,
    output logic                     if_dec_valid,
    input  logic                     if_dec_ready,
    output logic [$clog2(DEPTH):0]   ifq_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("ifq: DEPTH must be a power of two between 2 and 16");
    end

    ifq_entry_t    mem [DEPTH];
    ifq_entry_t    head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          push;
    logic          pop;

    // Handshakes depend only on registered occupancy, so a full queue cannot accept in a pop cycle.
    assign ifp_ifq_ready = (level != LW'(DEPTH));
    assign if_dec_valid  = (level != '0);
    assign push          = ifp_ifq_valid & ifp_ifq_ready & ~pipe_flush;
    assign pop           = if_dec_valid & if_dec_ready & ~pipe_flush;

    always_ff @(posedge clk) begin
        if (rst || pipe_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Entry storage is not reset; stale contents are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: ifp_ifq_pc, instr: ifp_ifq_instr, bp: ifp_ifq_bp, bt: ifp_ifq_bt};
        end
    end

    assign head         = mem[rd_ptr];
    assign if_dec_pc    = head.pc;
    assign if_dec_instr = head.instr;
    assign if_dec_bp    = head.bp;
    assign if_dec_bt    = head.bt;
    assign ifq_level    = level;

endmodule

// File: tb/tb_ifq.sv
// Scoreboard bench for ifq: a queue model tracks accepted entries and the expected head each cycle.
module tb_ifq;
    import ifq_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $bits(ifq_entry_t);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_flush = 1'b0;
    logic [63:0] ifp_ifq_pc = '0;
    logic [31:0] ifp_ifq_instr = '0;
    logic        ifp_ifq_bp = 1'b0;
    logic [63:0] ifp_ifq_bt = '0;
    logic        ifp_ifq_valid = 1'b0;
    logic        ifp_ifq_ready;
    logic [63:0] if_dec_pc;
    logic [31:0] if_dec_instr;
    logic        if_dec_bp;
    logic [63:0] if_dec_bt;
    logic        if_dec_valid;
    logic        if_dec_ready = 1'b0;
    logic [2:0]  ifq_level;

    ifq #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pipe_flush(pipe_flush),
        .ifp_ifq_pc(ifp_ifq_pc), .ifp_ifq_instr(ifp_ifq_instr),
        .ifp_ifq_bp(ifp_ifq_bp), .ifp_ifq_bt(ifp_ifq_bt),
        .ifp_ifq_valid(ifp_ifq_valid), .ifp_ifq_ready(ifp_ifq_ready),
        .if_dec_pc(if_dec_pc), .if_dec_instr(if_dec_instr),
        .if_dec_bp(if_dec_bp), .if_dec_bt(if_dec_bt),
        .if_dec_valid(if_dec_valid), .if_dec_ready(if_dec_ready),
        .ifq_level(ifq_level)
    );

    always #5 clk = ~clk;

    ifq_entry_t sb [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ifq_entry_t mk(input logic [63:0] pc, input logic [31:0] instr);
        ifq_entry_t e;
        e.pc = pc; e.instr = instr; e.bp = pc[2]; e.bt = pc + 64'h40;
        return e;
    endfunction

    // Drive one cycle, check outputs against the model, then update the model at the edge.
    task automatic cycle(input logic v, input ifq_entry_t e, input logic rdy,
                         input logic fl, input logic r, output logic acc);
        logic do_push, do_pop;
        ifp_ifq_valid = v; ifp_ifq_pc = e.pc; ifp_ifq_instr = e.instr;
        ifp_ifq_bp = e.bp; ifp_ifq_bt = e.bt;
        if_dec_ready = rdy; pipe_flush = fl; rst = r;
        #1;
        check("ready", CW'(ifp_ifq_ready), CW'(sb.size() != DEPTH));
        check("valid", CW'(if_dec_valid), CW'(sb.size() != 0));
        check("level", CW'(ifq_level), CW'(sb.size()));
        if (sb.size() != 0)
            check("head", CW'({if_dec_pc, if_dec_instr, if_dec_bp, if_dec_bt}), CW'(sb[0]));
        do_push = v && (sb.size() < DEPTH) && !fl && !r;
        do_pop  = rdy && (sb.size() > 0) && !fl && !r;
        acc = do_push;
        if (r || fl) sb.delete();
        else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    ifq_entry_t idle;
    logic acc;
    int pushed;
    int cyc;

    initial begin
        idle = mk(64'h0, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        cycle(1'b0, idle, 1'b0, 1'b0, 1'b0, acc);

        // Fill with decoder stalled, then drain in order.
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(64'h1000 + 64'(4 * i), 32'(i)), 1'b0, 1'b0, 1'b0, acc);
        check("full_level", CW'(ifq_level), CW'(4));
        check("full_ready", CW'(ifp_ifq_ready), CW'(0));
        check("full_pc", CW'(if_dec_pc), CW'(64'h1000));
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", CW'(if_dec_pc), CW'(64'h1000 + 64'(4 * i)));
            cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        end
        check("empty_valid", CW'(if_dec_valid), CW'(0));

        // Full queue: push+pop in one cycle only pops.
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(64'h2000 + 64'(4 * i), 32'h100 + 32'(i)), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, mk(64'h2FF0, 32'hDEAD), 1'b1, 1'b0, 1'b0, acc);
        check("full_pop_level", CW'(ifq_level), CW'(3));
        check("full_pop_ready", CW'(ifp_ifq_ready), CW'(1));

        // Level 1 push+pop: level holds and new entry appears.
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        cycle(1'b1, mk(64'h3000, 32'h00000013), 1'b1, 1'b0, 1'b0, acc);
        check("pp_level", CW'(ifq_level), CW'(1));
        check("pp_instr", CW'(if_dec_instr), CW'(32'h00000013));

        // Flush at level 3 with a push pending.
        cycle(1'b1, mk(64'h3004, 32'h1), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, mk(64'h3008, 32'h2), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, mk(64'h300C, 32'h3), 1'b1, 1'b1, 1'b0, acc);
        check("flush_level", CW'(ifq_level), CW'(0));
        check("flush_valid", CW'(if_dec_valid), CW'(0));
        cycle(1'b1, mk(64'h4000, 32'h44), 1'b0, 1'b0, 1'b0, acc);
        check("post_flush_pc", CW'(if_dec_pc), CW'(64'h4000));
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);

        // Random backpressure across pointer wrap; head compared every cycle checks stall stability.
        pushed = 0;
        cyc = 0;
        while ((pushed < 10 || sb.size() != 0) && cyc < 300) begin
            cycle(pushed < 10 && $urandom_range(0, 3) != 0,
                  mk({$urandom, $urandom}, $urandom), $urandom_range(0, 2) == 0, 1'b0, 1'b0, acc);
            if (acc) pushed++;
            cyc++;
        end
        check("rand_drained", CW'(cyc < 300), CW'(1));
        check("rand_pushed", CW'(pushed), CW'(10));

        // Reset at level 2 overrides flush and push.
        cycle(1'b1, mk(64'h5000, 32'h5), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, mk(64'h5004, 32'h6), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, mk(64'h5008, 32'h7), 1'b0, 1'b1, 1'b1, acc);
        check("rst_level", CW'(ifq_level), CW'(0));
        check("rst_valid", CW'(if_dec_valid), CW'(0));
        check("rst_ready", CW'(ifp_ifq_ready), CW'(1));
        cycle(1'b0, idle, 1'b0, 1'b0, 1'b0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ifq.md
IFQ -- requirements
Module: ifq

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, 2 to 16.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 pipe_flush  input  1  discard all queued instructions.
REQ-005 ifp_ifq_pc  input  64  PC of the incoming fetched instruction.
REQ-006 ifp_ifq_instr  input  32  incoming instruction word.
REQ-007 ifp_ifq_bp  input  1  branch-predicted-taken flag.
REQ-008 ifp_ifq_bt  input  64  predicted branch target.
REQ-009 ifp_ifq_valid  input  1  upstream entry valid.
REQ-010 ifp_ifq_ready  output  1  queue can accept an entry this cycle.
REQ-011 if_dec_pc  output  64  head entry PC.
REQ-012 if_dec_instr  output  32  head entry instruction.
REQ-013 if_dec_bp  output  1  head entry predicted-taken flag.
REQ-014 if_dec_bt  output  64  head entry predicted target.
REQ-015 if_dec_valid  output  1  head entry present.
REQ-016 if_dec_ready  input  1  decoder consumes head entry this cycle.
REQ-017 ifq_level  output  log2(DEPTH)+1  current occupancy.

Function
REQ-018 Push SHALL occur when ifp_ifq_valid and ifp_ifq_ready are both 1 and pipe_flush is 0; entry {pc, instr, bp, bt} SHALL be written at the write pointer.
REQ-019 Pop SHALL occur when if_dec_valid and if_dec_ready are both 1 and pipe_flush is 0; the read pointer SHALL advance by one.
REQ-020 Write and read pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-021 ifq_level SHALL increment on push-only, decrement on pop-only, and hold on push+pop or on neither.
REQ-022 ifp_ifq_ready SHALL equal (ifq_level != DEPTH), derived from registered state only, with no combinational path from if_dec_ready.
REQ-023 When full, a same-cycle pop SHALL NOT enable a push; ready rises the cycle after the pop.
REQ-024 if_dec_valid SHALL equal (ifq_level != 0); there is no bypass, so an entry pushed in cycle N is first visible at the output in cycle N+1 (latency 1).
REQ-025 if_dec_pc/instr/bp/bt SHALL present the entry at the read pointer (first-word-fall-through) and SHALL remain stable while if_dec_valid=1 and if_dec_ready=0.
REQ-026 When if_dec_valid=0, the data outputs are don't-care.
REQ-027 Simultaneous push and pop at level 1 SHALL leave level 1, and the new entry SHALL appear at the output in the next cycle.
REQ-028 pipe_flush=1 SHALL, in the same edge, zero both pointers and ifq_level and suppress any push or pop asserted in that cycle.
REQ-029 pipe_flush SHALL take effect regardless of ifp_ifq_valid, if_dec_ready or occupancy; the queue SHALL accept pushes again in the following cycle.
REQ-030 Entry storage SHALL NOT require reset; only pointers and level are reset.
REQ-031 Entries SHALL leave the queue in strict push order; no entry SHALL be duplicated or dropped except by flush or reset.

Reset
REQ-032 rst=1 SHALL, at the next rising edge, zero both pointers and ifq_level, giving if_dec_valid=0 and ifp_ifq_ready=1; rst SHALL take priority over pipe_flush, push and pop.
REQ-033 rst asserted mid-operation, with a partially full queue, SHALL discard all entries with the same result as REQ-032.

Verification
REQ-034 Push PCs 0x1000, 0x1004, 0x1008, 0x100C with if_dec_ready=0 -> level 4, ifp_ifq_ready=0 and if_dec_pc=0x1000; then pop 4 times -> PCs out in order 0x1000 to 0x100C, then if_dec_valid=0.
REQ-035 With the queue full, assert if_dec_ready=1 and ifp_ifq_valid=1 in one cycle -> only a pop occurs, level 3, and ready=1 in the next cycle.
REQ-036 At level 1, push instr 0x00000013 and pop in the same cycle -> level stays 1 and if_dec_instr=0x00000013 in the next cycle.
REQ-037 At level 3, assert pipe_flush with ifp_ifq_valid=1 -> next cycle level 0 and if_dec_valid=0; a push in the following cycle appears at the output one cycle later.
REQ-038 Fill 10 entries with random if_dec_ready backpressure, so the pointers wrap -> output sequence equals input sequence, and if_dec_pc/instr/bp/bt stay stable during every stall cycle.
REQ-039 Assert rst at level 2 together with pipe_flush and ifp_ifq_valid -> next cycle level 0, if_dec_valid=0 and ifp_ifq_ready=1.
